// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the HI/LO multiply/divide unit
//   - ALU_* control codes for the HI/LO group driven by the decoder
//   - state_e : IDLE / RUN / DONE sequencing of the iterative unit
//   - DIV0_LO : LO value committed on a divide by zero
package muldiv_pkg;
   localparam logic [4:0] ALU_MULT  = 5'd10;
   localparam logic [4:0] ALU_MULTU = 5'd11;
   localparam logic [4:0] ALU_DIV   = 5'd12;
   localparam logic [4:0] ALU_DIVU  = 5'd13;
   localparam logic [4:0] ALU_MTHI  = 5'd14;
   localparam logic [4:0] ALU_MTLO  = 5'd15;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
   localparam logic [31:0] DIV0_LO = '1;
endpackage

// File: rtl/muldiv_iter_core.sv
// muldiv_iter_core: unsigned magnitude datapath, one mul or div step per cycle
//   clk, rst           : clock, synchronous active-high reset
//   load_i             : latch magnitudes a_i/b_i and the operation kind
//   step_i             : perform one shift-add (mul) or restoring step (div)
//   is_div_i           : operation kind sampled with load_i
//   a_i, b_i           : operand magnitudes
//   res_hi_o, res_lo_o : accumulator value after the current step
module muldiv_iter_core #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             step_i,
   input  logic             is_div_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] res_hi_o,
   output logic [WIDTH-1:0] res_lo_o
);
   logic [2*WIDTH-1:0] acc_q, acc_d, step_acc;
   logic [WIDTH-1:0]   b_q, b_d;
   logic               is_div_q, is_div_d;
   logic [WIDTH:0]     sum, trial;
   always_comb begin
      // mul: add multiplicand on LSB of multiplier, shift right with the carry
      sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, acc_q[0] ? b_q : {WIDTH{1'b0}}};
      // div: shifted partial remainder minus divisor; MSB set means borrow
      trial    = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, b_q};
      step_acc = is_div_q ? (trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                          : {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1})
                          : {sum, acc_q[WIDTH-1:1]};
      acc_d    = load_i ? {{WIDTH{1'b0}}, a_i} : step_i ? step_acc : acc_q;
      b_d      = load_i ? b_i : b_q;
      is_div_d = load_i ? is_div_i : is_div_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q    <= '0;
         b_q      <= '0;
         is_div_q <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         b_q      <= b_d;
         is_div_q <= is_div_d;
      end
   end
   assign res_hi_o = step_acc[2*WIDTH-1:WIDTH];
   assign res_lo_o = step_acc[WIDTH-1:0];
endmodule

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: HI/LO registers with iterative mult/div and MTHI/MTLO
//   clk, rst         : clock, synchronous active-high reset
//   flush_i, stall_i : pipeline flush of EX / downstream stall
//   valid_i          : EX instruction valid
//   alucontrol_i     : ALU control code
//   srca_i, srcb_i   : rs / rt operands
//   busy_o, done_o   : pipeline stall request / result committed
//   hi_o, lo_o       : architectural HI / LO
module hilo_muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int ITER  = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush_i,
   input  logic             stall_i,
   input  logic             valid_i,
   input  logic [4:0]       alucontrol_i,
   input  logic [WIDTH-1:0] srca_i,
   input  logic [WIDTH-1:0] srcb_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);
   localparam int CW = $clog2(ITER);
   state_e             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic               neg_q, neg_d, rneg_q, rneg_d, div_q, div_d;
   logic               is_mul, is_div, is_sgn, idle_ok, start, div0, last;
   logic [WIDTH-1:0]   a_mag, b_mag, res_hi, res_lo;
   logic [2*WIDTH-1:0] prod, prod_fix;
   assign is_mul   = alucontrol_i == ALU_MULT || alucontrol_i == ALU_MULTU;
   assign is_div   = alucontrol_i == ALU_DIV || alucontrol_i == ALU_DIVU;
   assign is_sgn   = alucontrol_i == ALU_MULT || alucontrol_i == ALU_DIV;
   assign idle_ok  = valid_i & ~flush_i & (state_q == IDLE);
   assign start    = idle_ok & (is_mul | is_div);
   assign div0     = is_div & (srcb_i == '0);
   assign last     = (state_q == RUN) & ~flush_i & (cnt_q == '0);
   assign a_mag    = (is_sgn & srca_i[WIDTH-1]) ? -srca_i : srca_i;
   assign b_mag    = (is_sgn & srcb_i[WIDTH-1]) ? -srcb_i : srcb_i;
   assign prod     = {res_hi, res_lo};
   assign prod_fix = neg_q ? -prod : prod;
   muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
      .clk      (clk),
      .rst      (rst),
      .load_i   (start),
      .step_i   (state_q == RUN),
      .is_div_i (is_div),
      .a_i      (a_mag),
      .b_i      (b_mag),
      .res_hi_o (res_hi),
      .res_lo_o (res_lo)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         div_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         div_q   <= div_d;
      end
   end
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = start ? (div0 ? DONE : RUN) : IDLE;
         RUN:     state_d = flush_i ? IDLE : (cnt_q == '0 ? DONE : RUN);
         DONE:    state_d = stall_i ? DONE : IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      cnt_d  = start ? CW'(ITER - 1) : (state_q == RUN ? cnt_q - CW'(1) : cnt_q);
      // quotient/product sign and remainder sign follow the operand signs
      neg_d  = start ? is_sgn & (srca_i[WIDTH-1] ^ srcb_i[WIDTH-1]) : neg_q;
      rneg_d = start ? is_sgn & srca_i[WIDTH-1] : rneg_q;
      div_d  = start ? is_div : div_q;
      hi_d   = hi_q;
      lo_d   = lo_q;
      if (idle_ok && alucontrol_i == ALU_MTHI) hi_d = srca_i;
      if (idle_ok && alucontrol_i == ALU_MTLO) lo_d = srca_i;
      if (start && div0) begin
         hi_d = srca_i;
         lo_d = DIV0_LO[WIDTH-1:0];
      end
      if (last) begin
         hi_d = div_q ? (rneg_q ? -res_hi : res_hi) : prod_fix[2*WIDTH-1:WIDTH];
         lo_d = div_q ? (neg_q ? -res_lo : res_lo) : prod_fix[WIDTH-1:0];
      end
   end
   always_comb begin
      busy_o = (state_q == IDLE) ? start : (state_q == RUN) & ~flush_i;
      done_o = state_q == DONE;
      hi_o   = hi_q;
      lo_o   = lo_q;
   end
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit: directed and random checks of hilo_muldiv_unit against an arithmetic model
module tb_hilo_muldiv_unit;
   import muldiv_pkg::*;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush_i = 1'b0;
   logic        stall_i = 1'b0;
   logic        valid_i = 1'b0;
   logic [4:0]  alucontrol_i = '0;
   logic [31:0] srca_i = '0;
   logic [31:0] srcb_i = '0;
   logic        busy_o, done_o;
   logic [31:0] hi_o, lo_o;
   int          n_tests = 0;
   int          n_fail = 0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;
   always #5 clk = ~clk;
   hilo_muldiv_unit #(.WIDTH(32), .ITER(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .flush_i      (flush_i),
      .stall_i      (stall_i),
      .valid_i      (valid_i),
      .alucontrol_i (alucontrol_i),
      .srca_i       (srca_i),
      .srcb_i       (srcb_i),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .hi_o         (hi_o),
      .lo_o         (lo_o)
   );
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   function automatic void ref_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo);
      longint      sa, sb, q, r;
      logic [63:0] p;
      sa = $signed(a);
      sb = $signed(b);
      hi = a;
      lo = 32'hFFFF_FFFF;
      if (op == ALU_MULT) begin
         p  = sa * sb;
         hi = p[63:32];
         lo = p[31:0];
      end else if (op == ALU_MULTU) begin
         p  = {32'd0, a} * {32'd0, b};
         hi = p[63:32];
         lo = p[31:0];
      end else if (op == ALU_DIV && b != 0) begin
         q  = sa / sb;
         r  = sa % sb;
         hi = r[31:0];
         lo = q[31:0];
      end else if (op == ALU_DIVU && b != 0) begin
         hi = a % b;
         lo = a / b;
      end
   endfunction
   task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int stall_n);
      int lat, busy_n, exp_lat;
      lat = 0;
      busy_n = 0;
      exp_lat = ((op == ALU_DIV || op == ALU_DIVU) && b == 0) ? 1 : 33;
      @(negedge clk);
      valid_i = 1'b1;
      alucontrol_i = op;
      srca_i = a;
      srcb_i = b;
      #1 check({tag, "_start_busy"}, 64'(busy_o), 64'd1);
      ref_op(op, a, b, m_hi, m_lo);
      @(posedge clk);
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (stall_n == 0) valid_i = 1'b0;
         if (done_o) begin
            lat = i;
            break;
         end
         if (busy_o) busy_n++;
      end
      check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      check({tag, "_busy_cycles"}, 64'(busy_n + 1), 64'(exp_lat));
      check({tag, "_hi"}, 64'(hi_o), 64'(m_hi));
      check({tag, "_lo"}, 64'(lo_o), 64'(m_lo));
      if (stall_n > 0) begin
         stall_i = 1'b1;
         srca_i = $urandom;
         srcb_i = $urandom;
         for (int k = 1; k <= stall_n; k++) begin
            @(negedge clk);
            check({tag, "_stall_done"}, 64'(done_o), 64'd1);
            check({tag, "_stall_busy"}, 64'(busy_o), 64'd0);
            check({tag, "_stall_hilo"}, {hi_o, lo_o}, {m_hi, m_lo});
            if (k == stall_n) begin
               stall_i = 1'b0;
               valid_i = 1'b0;
            end
         end
      end
      @(negedge clk);
      check({tag, "_done_drop"}, 64'(done_o), 64'd0);
      check({tag, "_after_hilo"}, {hi_o, lo_o}, {m_hi, m_lo});
   endtask
   task automatic mt_op(input logic [4:0] op, input logic [31:0] v, input logic fl);
      @(negedge clk);
      valid_i = 1'b1;
      alucontrol_i = op;
      srca_i = v;
      flush_i = fl;
      #1 check("mt_busy", 64'(busy_o), 64'd0);
      @(negedge clk);
      valid_i = 1'b0;
      flush_i = 1'b0;
      if (!fl && op == ALU_MTHI) m_hi = v;
      if (!fl && op == ALU_MTLO) m_lo = v;
      check("mt_hilo", {hi_o, lo_o}, {m_hi, m_lo});
   endtask
   initial begin
      logic [4:0]  ops [4];
      logic [31:0] ra, rb;
      int          dn;
      ops[0] = ALU_MULT;
      ops[1] = ALU_MULTU;
      ops[2] = ALU_DIV;
      ops[3] = ALU_DIVU;
      repeat (2) @(negedge clk);
      check("rst_busy", 64'(busy_o), 64'd0);
      check("rst_done", 64'(done_o), 64'd0);
      check("rst_hi", 64'(hi_o), 64'd0);
      check("rst_lo", 64'(lo_o), 64'd0);
      rst = 1'b0;
      run_op("mult_neg", ALU_MULT, 32'hFFFF_FFFD, 32'd5, 0);
      check("mult_neg_hi_const", 64'(hi_o), 64'hFFFF_FFFF);
      check("mult_neg_lo_const", 64'(lo_o), 64'hFFFF_FFF1);
      run_op("divu", ALU_DIVU, 32'd100, 32'd7, 0);
      check("divu_const", {hi_o, lo_o}, {32'd2, 32'd14});
      run_op("div_neg", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 0);
      check("div_neg_const", {hi_o, lo_o}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      run_op("div0", ALU_DIV, 32'h1234, 32'd0, 0);
      check("div0_const", {hi_o, lo_o}, {32'h1234, 32'hFFFF_FFFF});
      run_op("div_ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      check("div_ovf_const", {hi_o, lo_o}, {32'd0, 32'h8000_0000});
      // flush mid-run: busy drops at once, HI/LO untouched, no completion
      @(negedge clk);
      valid_i = 1'b1;
      alucontrol_i = ALU_MULTU;
      srca_i = 32'hDEAD_BEEF;
      srcb_i = 32'h1234_5678;
      @(posedge clk);
      @(negedge clk);
      valid_i = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      flush_i = 1'b1;
      #1 check("flush_busy_now", 64'(busy_o), 64'd0);
      @(posedge clk);
      #1 flush_i = 1'b0;
      @(negedge clk);
      check("flush_idle_busy", 64'(busy_o), 64'd0);
      check("flush_hilo", {hi_o, lo_o}, {m_hi, m_lo});
      dn = 0;
      repeat (35) begin
         @(negedge clk);
         if (done_o) dn++;
      end
      check("flush_no_done", 64'(dn), 64'd0);
      check("flush_hilo_late", {hi_o, lo_o}, {m_hi, m_lo});
      run_op("stall3", ALU_MULT, 32'h0001_0003, 32'hFFFF_0007, 3);
      mt_op(ALU_MTHI, 32'hA5A5_A5A5, 1'b0);
      mt_op(ALU_MTLO, 32'h5A5A_5A5A, 1'b0);
      mt_op(ALU_MTHI, 32'h1111_2222, 1'b1);
      mt_op(ALU_MTLO, 32'h3333_4444, 1'b1);
      for (int n = 0; n < 14; n++) begin
         ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
         rb = ($urandom_range(0, 5) == 0) ? 32'd0 :
              ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF :
              ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 50)) : $urandom;
         run_op("rand", ops[$urandom_range(0, 3)], ra, rb, $urandom_range(0, 2));
         if (n % 4 == 0) mt_op($urandom_range(0, 1) ? ALU_MTHI : ALU_MTLO, $urandom, 1'($urandom_range(0, 1)));
      end
      // reset in the middle of an operation clears everything
      @(negedge clk);
      valid_i = 1'b1;
      alucontrol_i = ALU_DIVU;
      srca_i = 32'hFFFF_0000;
      srcb_i = 32'd3;
      @(posedge clk);
      @(negedge clk);
      valid_i = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      m_hi = '0;
      m_lo = '0;
      check("rst_run_busy", 64'(busy_o), 64'd0);
      check("rst_run_done", 64'(done_o), 64'd0);
      check("rst_run_hilo", {hi_o, lo_o}, {m_hi, m_lo});
      rst = 1'b0;
      run_op("post_rst", ALU_MULT, 32'h7FFF_FFFF, 32'h8000_0000, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
